// File: rtl/lcd_axil_cmd_slave_if.sv
// AXI4-Lite slave-side bus bundle for the LCD command responder.
// The responder uses the slave modport and the PS/VIP side uses the master modport.
interface lcd_axil_cmd_slave_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/lcd_axil_cmd_slave.sv
// AXI4-Lite register block for the LCD IP: CTRL/DATA/CMD/SCRATCH, and a CMD write
// launches one command to the LCD timing engine over a valid/ready handshake.
module lcd_axil_cmd_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                   ACLK,
   input  logic                   ARESETN,
   lcd_axil_cmd_slave_if.slave    s_axi,
   output logic                   lcd_cmd_valid,
   output logic [8:0]             lcd_cmd_data,
   input  logic                   lcd_cmd_ready,
   output logic [30:0]            lcd_ctrl
);
   localparam int NB = C_S_AXI_DATA_WIDTH / 8;

   logic                          live;
   logic                          aw_held;
   logic                          w_held;
   logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
   logic [NB-1:0]                 w_strb_q;
   logic [30:0]                   ctrl_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] data_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] cmd_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] scratch_q;
   logic                          bvalid_q;
   logic [1:0]                    bresp_q;
   logic                          rvalid_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

   logic                          aw_hs;
   logic                          w_hs;
   logic                          ar_hs;
   logic                          do_write;
   logic [1:0]                    wr_sel;
   logic                          cmd_reject;
   logic                          cmd_launch;
   logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_next;
   logic [C_S_AXI_DATA_WIDTH-1:0] data_next;
   logic [C_S_AXI_DATA_WIDTH-1:0] cmd_next;
   logic [C_S_AXI_DATA_WIDTH-1:0] scratch_next;
   logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
   logic                          unused_ok;

   function automatic logic [C_S_AXI_DATA_WIDTH-1:0] merge(
      input logic [C_S_AXI_DATA_WIDTH-1:0] old_val,
      input logic [C_S_AXI_DATA_WIDTH-1:0] new_val,
      input logic [NB-1:0]                 strb
   );
      logic [C_S_AXI_DATA_WIDTH-1:0] res;
      res = old_val;
      for (int i = 0; i < NB; i++) begin
         if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

   // live keeps every READY low while reset is asserted and for the first edge after it.
   assign s_axi.awready = live & ~aw_held & ~bvalid_q;
   assign s_axi.wready  = live & ~w_held & ~bvalid_q;
   assign s_axi.arready = live & ~rvalid_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = 2'b00;
   assign lcd_ctrl      = ctrl_q;

   assign aw_hs      = s_axi.awvalid & s_axi.awready;
   assign w_hs       = s_axi.wvalid & s_axi.wready;
   assign ar_hs      = s_axi.arvalid & s_axi.arready;
   assign do_write   = aw_held & w_held & ~bvalid_q;
   assign wr_sel     = aw_addr_q[3:2];
   assign cmd_reject = do_write & (wr_sel == 2'd2) & lcd_cmd_valid;
   assign cmd_launch = do_write & (wr_sel == 2'd2) & ~lcd_cmd_valid & (w_strb_q[0] | w_strb_q[1]);

   assign ctrl_next    = merge({1'b0, ctrl_q}, w_data_q, w_strb_q);
   assign data_next    = merge(data_q, w_data_q, w_strb_q);
   assign cmd_next     = merge(cmd_q, w_data_q, w_strb_q);
   assign scratch_next = merge(scratch_q, w_data_q, w_strb_q);

   always_comb begin
      rd_mux = '0;
      case (s_axi.araddr[3:2])
         2'd0:    rd_mux = {lcd_cmd_valid, ctrl_q};
         2'd1:    rd_mux = data_q;
         2'd2:    rd_mux = cmd_q;
         default: rd_mux = scratch_q;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         live      <= 1'b0;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
      end else begin
         live <= 1'b1;
         if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= s_axi.awaddr;
         end
         if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= s_axi.wdata;
            w_strb_q <= s_axi.wstrb;
         end
         if (do_write) begin
            bvalid_q <= 1'b1;
            bresp_q  <= cmd_reject ? 2'b10 : 2'b00;
         end else if (bvalid_q && s_axi.bready) begin
            bvalid_q <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         ctrl_q        <= '0;
         data_q        <= '0;
         cmd_q         <= '0;
         scratch_q     <= '0;
         lcd_cmd_valid <= 1'b0;
         lcd_cmd_data  <= '0;
      end else begin
         if (do_write) begin
            case (wr_sel)
               2'd0:    ctrl_q    <= ctrl_next[30:0];
               2'd1:    data_q    <= data_next;
               2'd2:    if (!lcd_cmd_valid) cmd_q <= cmd_next;
               default: scratch_q <= scratch_next;
            endcase
         end
         // A launch can only happen while idle, so it never collides with the clear.
         if (lcd_cmd_valid && lcd_cmd_ready) lcd_cmd_valid <= 1'b0;
         if (cmd_launch) begin
            lcd_cmd_valid <= 1'b1;
            lcd_cmd_data  <= cmd_next[8:0];
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_mux;
      end else if (rvalid_q && s_axi.rready) begin
         rvalid_q <= 1'b0;
      end
   end

   assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.araddr[1:0], aw_addr_q[1:0]};
endmodule
